// File: rtl/codix_risc_port_rx.sv
// codix_risc_port_rx
// Receive side of the core output port. Words written by the core are
// queued in a show-ahead FIFO for a downstream consumer. A sticky halt
// capture records the core error code. A small FSM raises an interrupt
// back to the core when the fill level reaches THRESH, when a word is
// dropped on overflow, or when the core halts.

module codix_risc_port_rx #(
    parameter int DEPTH  = 8,
    parameter int THRESH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [31:0]                port_out,
    input  logic                       port_out_en,
    input  logic                       port_halt,
    input  logic [31:0]                port_error,
    output logic                       irq,
    input  logic                       irq_ack,
    output logic [31:0]                rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       halted,
    output logic [31:0]                error_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Fill-level constants at counter width so comparisons stay width-exact
    localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_LVL = CW'(THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          halted_reg;
    logic [31:0]   error_code_reg;
    state_t        state_reg;
    state_t        state_next;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic ovf_event;
    logic halt_event;
    logic over_thresh;

    // Pop only when data is present; rd_ready alone is ignored when empty.
    // A push into a full FIFO is still legal when the head leaves this cycle.
    // Once halted, writes are silently discarded and never count as overflow.
    always_comb begin
        is_full     = (count_reg == FULL_LVL);
        is_empty    = (count_reg == '0);
        pop         = !is_empty && rd_ready;
        push        = port_out_en && !halted_reg && (!is_full || pop);
        ovf_event   = port_out_en && !halted_reg && is_full && !pop;
        halt_event  = port_halt && !halted_reg;
        over_thresh = (count_reg >= THRESH_LVL);
    end

    // Fill level update: simultaneous push and pop leaves the level unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Word storage; not reset, validity is tracked by the pointers and count
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= port_out;
        end
    end

    // Pointers and fill level; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Sticky overflow: a dropped word sets it, an acknowledge in PEND clears
    // it, and a drop in the same cycle as the acknowledge takes priority
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_reg <= 1'b0;
        end else if (ovf_event) begin
            overflow_reg <= 1'b1;
        end else if (irq_ack && (state_reg == PEND)) begin
            overflow_reg <= 1'b0;
        end
    end

    // Halt capture: only the first halt cycle is recorded
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            halted_reg     <= 1'b0;
            error_code_reg <= '0;
        end else if (halt_event) begin
            halted_reg     <= 1'b1;
            error_code_reg <= port_error;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt FSM
    // ------------------------------------------------------------------

    // State register for the interrupt FSM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: HOLD waits for the level to fall below THRESH so a
    // standing high fill level does not retrigger immediately after an ack;
    // fresh overflow or halt events always re-raise the request
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (over_thresh || ovf_event || halt_event) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (irq_ack) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ovf_event || halt_event) begin
                    state_next = PEND;
                end else if (!over_thresh) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head word is gated so rd_data reads zero whenever the FIFO is empty
    assign rd_valid   = !is_empty;
    assign rd_data    = is_empty ? 32'h0 : mem[rd_ptr_reg];
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign halted     = halted_reg;
    assign error_code = error_code_reg;
    assign irq        = (state_reg == PEND);

endmodule

// File: tb/tb_codix_risc_port_rx.sv
// Testbench for codix_risc_port_rx (DEPTH=8, THRESH=4).
// Directed stimulus; accepted words are queued as expectations and a
// separate monitor compares every popped word against the queue head.

module tb_codix_risc_port_rx;

    logic        CLK;
    logic        RST;
    logic [31:0] port_out;
    logic        port_out_en;
    logic        port_halt;
    logic [31:0] port_error;
    logic        irq;
    logic        irq_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  count;
    logic        overflow;
    logic        halted;
    logic [31:0] error_code;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    codix_risc_port_rx #(.DEPTH(8), .THRESH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .port_out   (port_out),
        .port_out_en(port_out_en),
        .port_halt  (port_halt),
        .port_error (port_error),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .count      (count),
        .overflow   (overflow),
        .halted     (halted),
        .error_code (error_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: on every pop handshake compare the head word with the scoreboard
    always @(negedge CLK) begin
        if (RST && rd_valid && rd_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got=0x%08h expected=<none>", rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got=0x%08h expected=0x%08h", rd_data, e);
                end else begin
                    $display("pop  0x%08h", rd_data);
                end
            end
        end
    end

    // One clock cycle with the given write/read strobes; inputs change 1ns after the edge
    task automatic cyc(input logic en, input logic [31:0] d, input logic rdy);
        port_out_en = en;
        port_out    = d;
        rd_ready    = rdy;
        @(posedge CLK);
        #1;
        port_out_en = 1'b0;
        rd_ready    = 1'b0;
    endtask

    // Write a word; queue it as expected only if it should be accepted
    task automatic pushx(input logic [31:0] d, input logic rdy, input logic acc);
        if (acc) exp_q.push_back(d);
        cyc(1'b1, d, rdy);
    endtask

    task automatic ack_cyc();
        irq_ack = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        irq_ack = 1'b0;
    endtask

    // Watchdog so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; port_out = '0; port_out_en = 0; port_halt = 0;
        port_error = '0; irq_ack = 0; rd_ready = 0;
        repeat (3) @(posedge CLK);
        #1;
        // Reset state
        chk("rst_count",    32'(count),      32'd0);
        chk("rst_rd_valid", 32'(rd_valid),   32'd0);
        chk("rst_rd_data",  rd_data,         32'h0);
        chk("rst_irq",      32'(irq),        32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        chk("rst_halted",   32'(halted),     32'd0);
        chk("rst_err_code", error_code,      32'h0);
        RST = 1'b1;

        // Threshold: three words below THRESH, fourth reaches it
        pushx(32'h11, 1'b0, 1'b1);
        chk("first_head", rd_data, 32'h11);
        pushx(32'h22, 1'b0, 1'b1);
        pushx(32'h33, 1'b0, 1'b1);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_head",  rd_data,    32'h11);
        chk("t1_irq",   32'(irq),   32'd0);
        pushx(32'h44, 1'b0, 1'b1);
        chk("t1_count4", 32'(count), 32'd4);
        chk("t1_irq_lat", 32'(irq),  32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t1_irq_up", 32'(irq), 32'd1);

        // Fill to full, drop one, then push+pop at full
        pushx(32'h55, 1'b0, 1'b1);
        pushx(32'h66, 1'b0, 1'b1);
        pushx(32'h77, 1'b0, 1'b1);
        pushx(32'h88, 1'b0, 1'b1);
        chk("t2_full", 32'(count), 32'd8);
        pushx(32'hDEAD, 1'b0, 1'b0);
        chk("t2_drop_count", 32'(count),    32'd8);
        chk("t2_drop_ovf",   32'(overflow), 32'd1);
        pushx(32'hDEAD, 1'b1, 1'b1);
        chk("t2_pp_count", 32'(count),    32'd8);
        chk("t2_pp_ovf",   32'(overflow), 32'd1);

        // Acknowledge with count=5, drain to 3, refill to 4
        repeat (3) cyc(1'b0, 32'h0, 1'b1);
        chk("t3_count5", 32'(count), 32'd5);
        ack_cyc();
        chk("t3_ack_irq", 32'(irq),      32'd0);
        chk("t3_ack_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t3_count3", 32'(count), 32'd3);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t3_hold_irq", 32'(irq), 32'd0);
        pushx(32'h99, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t3_reirq", 32'(irq), 32'd1);
        ack_cyc();
        repeat (4) cyc(1'b0, 32'h0, 1'b1);
        chk("t3_empty", 32'(rd_valid), 32'd0);

        // Halt capture with a simultaneous accepted push
        port_halt = 1'b1; port_error = 32'h7;
        pushx(32'hA1, 1'b0, 1'b1);
        port_error = 32'h9;
        chk("t4_halted",  32'(halted), 32'd1);
        chk("t4_errcode", error_code,  32'h7);
        chk("t4_count",   32'(count),  32'd1);
        chk("t4_irq",     32'(irq),    32'd1);
        pushx(32'hB2, 1'b0, 1'b0);
        pushx(32'hB3, 1'b0, 1'b0);
        chk("t4_ign_count", 32'(count),    32'd1);
        chk("t4_ign_ovf",   32'(overflow), 32'd0);
        chk("t4_err_keep",  error_code,    32'h7);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t4_drained", 32'(rd_valid), 32'd0);

        // Reset, then 16 interleaved words across two pointer wraps
        RST = 1'b0; port_halt = 1'b0; port_error = '0;
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b1;
        chk("t5_halt_clr", 32'(halted), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pushx(32'h1000 + 32'(i), (i >= 2), 1'b1);
        end
        chk("t5_count2", 32'(count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            pushx(32'h2000 + 32'(i), 1'b0, 1'b1);
        end
        chk("t5_count6", 32'(count), 32'd6);
        chk("t5_irq",    32'(irq),   32'd1);

        // Mid-stream reset takes effect immediately
        RST = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_count", 32'(count),    32'd0);
        chk("t5_rst_valid", 32'(rd_valid), 32'd0);
        chk("t5_rst_irq",   32'(irq),      32'd0);
        chk("t5_rst_data",  rd_data,       32'h0);
        @(negedge CLK);
        RST = 1'b1;
        pushx(32'h77, 1'b0, 1'b1);
        chk("t5_post_count", 32'(count), 32'd1);
        chk("t5_post_head",  rd_data,    32'h77);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codix_risc_port_rx.md
CODIX_RISC_PORT_RX -- requirements
Module: codix_risc_port_rx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of two, 2..64).
REQ-002 The block SHALL have parameter THRESH, default 4, fill level (1..DEPTH) at which irq is requested.
REQ-003 Port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port RST  input  1  reset, asynchronous, active-low.
REQ-005 Port port_out  input  32  data word from the core output port.
REQ-006 Port port_out_en  input  1  port_out valid for this cycle.
REQ-007 Port port_halt  input  1  core halted indication.
REQ-008 Port port_error  input  32  core error code, valid while port_halt=1.
REQ-009 Port irq  output  1  interrupt request back to the core irq input.
REQ-010 Port irq_ack  input  1  one-cycle acknowledge of irq from the core/handler.
REQ-011 Port rd_data  output  32  FIFO head word (show-ahead).
REQ-012 Port rd_valid  output  1  FIFO not empty.
REQ-013 Port rd_ready  input  1  consumer accepts rd_data; a pop occurs when rd_valid and rd_ready are both 1.
REQ-014 Port count  output  clog2(DEPTH)+1  current fill level.
REQ-015 Port overflow  output  1  sticky: a word was dropped.
REQ-016 Port halted  output  1  sticky: core halt captured.
REQ-017 Port error_code  output  32  port_error captured on the first halt cycle.

Function
REQ-018 A push SHALL occur when port_out_en=1, halted=0, and (count<DEPTH or a pop occurs in the same cycle).
REQ-019 A push and a pop in the same cycle SHALL leave count unchanged; at full this SHALL NOT set overflow.
REQ-020 port_out_en=1 while full with no pop SHALL drop the word, leave FIFO contents unchanged, set overflow, and generate a one-cycle ovf_event.
REQ-021 A pop while empty SHALL be impossible (rd_valid=0), and rd_ready SHALL be ignored.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH exactly.
REQ-023 A pushed word SHALL be visible on rd_data/rd_valid in the cycle after the push edge (1-cycle latency into empty FIFO); rd_data SHALL hold while rd_valid=1 and no pop.
REQ-024 On the first cycle with port_halt=1 and halted=0, halted SHALL set, error_code SHALL load port_error, and a one-cycle halt_event SHALL be generated; later port_halt/port_error changes SHALL be ignored.
REQ-025 After halted=1, further port_out_en pushes SHALL be ignored without setting overflow; pops SHALL continue to drain the FIFO.
REQ-026 A push in the same cycle as the first halt cycle SHALL be accepted.
REQ-027 The irq FSM SHALL have states IDLE (irq=0), PEND (irq=1), HOLD (irq=0).
REQ-028 IDLE->PEND when count>=THRESH, ovf_event, or halt_event; irq is registered and rises the cycle after the condition is visible.
REQ-029 PEND->HOLD on irq_ack=1; irq_ack SHALL also clear overflow, unless ovf_event occurs in the same cycle (set wins).
REQ-030 HOLD->PEND on ovf_event or halt_event; otherwise HOLD->IDLE when count<THRESH.
REQ-031 irq_ack in IDLE or HOLD SHALL be ignored.

Reset
REQ-032 While RST=0: FIFO empty, pointers 0, count=0, rd_valid=0, rd_data=0, overflow=0, halted=0, error_code=0, irq=0, FSM=IDLE.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents immediately; the first push is accepted on the first rising edge with RST=1.

Verification
REQ-034 DEPTH=8, THRESH=4: push 0x11,0x22,0x33 with rd_ready=0 -> count=3, rd_data=0x11, irq=0; push 0x44 -> count=4, irq=1 next cycle.
REQ-035 Fill to 8, push 0xDEAD with rd_ready=0 -> word dropped, count=8, overflow=1; the same at full with rd_ready=1 -> count=8, overflow unchanged, tail=0xDEAD.
REQ-036 irq=1, pulse irq_ack with count=5 -> irq=0, FSM HOLD; pop twice to count=3 -> FSM IDLE; push one to count=4 -> irq=1 again.
REQ-037 port_halt=1 with port_error=0x0000_0007, then port_error=0x9 -> halted=1, error_code=0x7, irq=1; subsequent port_out_en pushes ignored, overflow=0.
REQ-038 Push 16 words interleaved with pops -> read order matches write order across two pointer wraps; RST=0 mid-stream -> count=0, rd_valid=0, irq=0 immediately.
